// File: rtl/prog_tick_gen.sv
// Multi-channel programmable tick / clock-enable generator.
// Each channel runs its own terminal count and mode: periodic pulse, square wave or one-shot.
module prog_tick_gen #(
    parameter int          N_CH       = 4,
    parameter int          W          = 26,
    parameter int unsigned DEFAULT_TC = 24_999_999,
    parameter logic [1:0]  DEFAULT_MD = 2'b01,
    localparam int         CHW        = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            en,
    input  logic            clr,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [W-1:0]    cfg_tc,
    input  logic [1:0]      cfg_mode,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq,
    output logic [N_CH-1:0] active
);

    typedef enum logic [1:0] {
        MODE_PULSE   = 2'b00,
        MODE_SQUARE  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [W-1:0] cnt;
        logic [W-1:0] tc;
        mode_e        mode;
        mode_e        mode_after_clr;
        logic         tick_q;
        logic         sq_q;
        logic         active_q;
        logic         hit;

        // An index at or beyond N_CH matches no channel, so such writes vanish.
        assign hit            = cfg_we && (cfg_ch == CHW'(i));
        assign mode_after_clr = hit ? mode_e'(cfg_mode) : mode;

        // NOTE: the reset branch is tested first in an edge-sensitive block so arst
        // acts immediately; all state uses non-blocking assignments to avoid races.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                cnt      <= '0;
                tc       <= W'(DEFAULT_TC);
                mode     <= mode_e'(DEFAULT_MD);
                tick_q   <= 1'b0;
                sq_q     <= 1'b0;
                active_q <= (DEFAULT_MD != MODE_ONESHOT);
            end else if (clr) begin
                // A coincident write still stores its config, but never arms a one-shot.
                cnt      <= '0;
                tick_q   <= 1'b0;
                sq_q     <= 1'b0;
                active_q <= (mode_after_clr != MODE_ONESHOT);
                if (hit) begin
                    tc   <= cfg_tc;
                    mode <= mode_e'(cfg_mode);
                end
            end else if (hit) begin
                tc       <= cfg_tc;
                mode     <= mode_e'(cfg_mode);
                cnt      <= '0;
                tick_q   <= 1'b0;
                active_q <= 1'b1;
            end else if (en && active_q) begin
                if (cnt == tc) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    sq_q   <= ~sq_q;
                    if (mode == MODE_ONESHOT) begin
                        active_q <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + 1'b1;
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign tick[i]   = tick_q;
        assign sq[i]     = sq_q;
        assign active[i] = active_q;
    end

endmodule

// File: tb/tb_prog_tick_gen.sv
// Bench for prog_tick_gen: directed scenarios then random traffic, checked every cycle
// against an elapsed-cycle model; a second 5-channel instance sees only out-of-range writes.
module tb_prog_tick_gen;

    localparam int N   = 4;
    localparam int NB  = 5;
    localparam int W   = 26;
    localparam int TC0 = 3;

    logic          clk = 1'b0;
    logic          arst;
    logic          en;
    logic          clr;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_tc;
    logic [1:0]    cfg_mode;
    logic [N-1:0]  tick, sq, active;
    logic [NB-1:0] tick_b, sq_b, active_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prog_tick_gen #(.N_CH(N), .W(W), .DEFAULT_TC(TC0), .DEFAULT_MD(2'b01)) dut (
        .clk(clk), .arst(arst), .en(en), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_tc(cfg_tc), .cfg_mode(cfg_mode), .tick(tick), .sq(sq), .active(active)
    );

    prog_tick_gen #(.N_CH(NB), .W(W), .DEFAULT_TC(TC0), .DEFAULT_MD(2'b01)) dut_b (
        .clk(clk), .arst(arst), .en(en), .clr(clr), .cfg_we(cfg_we), .cfg_ch(3'd7),
        .cfg_tc(cfg_tc), .cfg_mode(cfg_mode), .tick(tick_b), .sq(sq_b), .active(active_b)
    );

    // Model: per channel, enabled active cycles since the last restart ("elapsed").
    // Ticks fall where elapsed is a multiple of the period; sq is the tick-count parity.
    longint m_tc[N];
    bit [1:0] m_mode[N];
    longint m_el[N];
    bit     m_base[N];
    bit     m_armed[N];
    bit     m_tick[N];
    longint b_el;
    bit     b_base;
    bit     b_tick;

    function automatic longint period(int i);
        return m_tc[i] + 1;
    endfunction

    function automatic bit exp_sq(int i);
        return m_base[i] ^ bit'((m_el[i] / period(i)) % 2);
    endfunction

    function automatic bit exp_active(int i);
        if (m_mode[i] != 2'b10) return 1'b1;
        return m_armed[i] && (m_el[i] < period(i));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_tc[i] = TC0; m_mode[i] = 2'b01; m_el[i] = 0;
            m_base[i] = 0; m_armed[i] = 0; m_tick[i] = 0;
        end
        b_el = 0; b_base = 0; b_tick = 0;
    endtask

    task automatic model_edge(bit e, bit c, bit we, int ch, int tcv, int md);
        bit hit;
        for (int i = 0; i < N; i++) begin
            hit = we && (ch == i);
            if (c) begin
                m_base[i] = 0; m_el[i] = 0; m_tick[i] = 0; m_armed[i] = 0;
                if (hit) begin m_tc[i] = tcv; m_mode[i] = md[1:0]; end
            end else if (hit) begin
                m_base[i] = exp_sq(i);
                m_el[i] = 0; m_tc[i] = tcv; m_mode[i] = md[1:0];
                m_armed[i] = 1; m_tick[i] = 0;
            end else if (e && exp_active(i)) begin
                m_el[i]++;
                m_tick[i] = (m_el[i] % period(i)) == 0;
            end else begin
                m_tick[i] = 0;
            end
        end
        if (c) begin
            b_el = 0; b_base = 0; b_tick = 0;
        end else if (e) begin
            b_el++;
            b_tick = (b_el % (TC0 + 1)) == 0;
        end else begin
            b_tick = 0;
        end
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] et, es, ea;
        bit bsq;
        for (int i = 0; i < N; i++) begin
            et[i] = m_tick[i]; es[i] = exp_sq(i); ea[i] = exp_active(i);
        end
        bsq = b_base ^ bit'((b_el / (TC0 + 1)) % 2);
        check({tag, ".tick"},     16'(tick),     16'(et));
        check({tag, ".sq"},       16'(sq),       16'(es));
        check({tag, ".active"},   16'(active),   16'(ea));
        check({tag, ".b_tick"},   16'(tick_b),   16'({NB{b_tick}}));
        check({tag, ".b_sq"},     16'(sq_b),     16'({NB{bsq}}));
        check({tag, ".b_active"}, 16'(active_b), 16'({NB{1'b1}}));
    endtask

    task automatic step(string tag, bit e, bit c, bit we, int ch, int tcv, int md);
        en = e; clr = c; cfg_we = we;
        cfg_ch = 2'(ch); cfg_tc = W'(tcv); cfg_mode = 2'(md);
        @(posedge clk);
        model_edge(e, c, we, ch, tcv, md);
        #1;
        check_all(tag);
    endtask

    initial begin
        arst = 1'b1; en = 1'b0; clr = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_tc = '0; cfg_mode = '0;
        model_reset();
        #8;
        check_all("reset");
        #4 arst = 1'b0;

        // Default rate: tick every 4 cycles, sq period 8.
        repeat (12) step("t1_default", 1, 0, 0, 0, 0, 0);

        // tc=0 ticks every cycle; then tc=5 gives the first tick 6 cycles after the write.
        step("t2_wr_tc0", 1, 0, 1, 1, 0, 0);
        repeat (5) step("t2_tc0", 1, 0, 0, 0, 0, 0);
        step("t2_wr_tc5", 1, 0, 1, 1, 5, 0);
        repeat (8) step("t2_tc5", 1, 0, 0, 0, 0, 0);

        // One-shot with tc=2: a single tick 3 cycles later, then idle.
        step("t3_wr_os", 1, 0, 1, 2, 2, 2);
        repeat (20) step("t3_os", 1, 0, 0, 0, 0, 0);

        // Hold with en low, then resume without catch-up.
        repeat (2) step("t4_pre", 1, 0, 0, 0, 0, 0);
        repeat (10) step("t4_hold", 0, 0, 0, 0, 0, 0);
        repeat (6) step("t4_resume", 1, 0, 0, 0, 0, 0);

        // clr wins over a coincident write; the stored config still takes effect.
        step("t5_clr_os", 1, 1, 1, 2, 4, 2);
        repeat (6) step("t5_idle", 1, 0, 0, 0, 0, 0);
        step("t5_clr_pulse", 1, 1, 1, 0, 4, 0);
        repeat (12) step("t5_tc4", 1, 0, 0, 0, 0, 0);

        // Reserved mode behaves as pulse mode.
        step("t6_wr_rsvd", 1, 0, 1, 3, 1, 3);
        repeat (6) step("t6_rsvd", 1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-count, away from the clock edge.
        #2 arst = 1'b1;
        #1 model_reset();
        check_all("t6_arst");
        #2 arst = 1'b0;
        repeat (9) step("t6_after_arst", 1, 0, 0, 0, 0, 0);

        // Random traffic: mostly enabled, occasional writes and clears.
        for (int k = 0; k < 600; k++) begin
            step("rand",
                 ($urandom % 8) != 0,
                 ($urandom % 40) == 0,
                 ($urandom % 6) == 0,
                 int'($urandom % 4),
                 int'($urandom % 7),
                 int'($urandom % 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
